// File: rtl/line_fill_responder.sv
// line_fill_responder: memory-side responder for the L1 miss/writeback port.
// Models a fixed DELAY-cycle backing store with DEPTH in-order request slots.
// Line-fill reads return a response; writebacks retire silently.
// Optional feature macro: MEM_ERR_CHECK_EN (flag line addresses >= MEM_BYTES).
module line_fill_responder #(
  parameter int unsigned DELAY      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LINE_BYTES = 64,
  parameter logic [31:0] MEM_BYTES  = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_id,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_addr,
  output logic [1:0]  resp_id,
  output logic        resp_err,
  output logic [31:0] rd_count,
  output logic [31:0] wb_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [31:0]      LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [31:0]      DELAY_C   = 32'(DELAY);

`ifdef MEM_ERR_CHECK_EN
  localparam logic ERR_CHECK = 1'b1;
`else
  localparam logic ERR_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  id;
    logic        write;
    logic        err;
    logic [31:0] due;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    RESP   = 2'd2,
    RETIRE = 2'd3
  } state_t;

  entry_t           slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic [31:0]      cyc;
  logic [31:0]      cyc_next;

  state_t           state;
  state_t           state_d;

  logic             push;
  logic             pop;
  logic             rd_inc;
  logic             wb_inc;
  entry_t           new_entry;
  entry_t           cand;
  logic             cand_valid;
  logic             cand_due;
  logic [31:0]      due_diff;

  logic             resp_valid_d;
  logic [31:0]      resp_addr_d;
  logic [1:0]       resp_id_d;
  logic             resp_err_d;

  // Request acceptance and the slot image of an incoming request
  always_comb begin
    push            = req_valid && req_ready;
    new_entry.addr  = req_addr & LINE_MASK;
    new_entry.id    = req_id;
    new_entry.write = req_write;
    new_entry.err   = ERR_CHECK && ((req_addr & LINE_MASK) >= MEM_BYTES);
    new_entry.due   = cyc + DELAY_C;
  end

  assign cyc_next   = cyc + 32'd1;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // Slot storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (push) begin
      slots[wr_ptr] <= new_entry;
    end
  end

  // Head FSM next state and registered response outputs. Decisions target the
  // coming edge, so due-ness is judged against cyc_next. When the head leaves
  // this cycle the entry behind it is examined so responses can run 1/cycle.
  always_comb begin
    state_d      = state;
    resp_valid_d = resp_valid;
    resp_addr_d  = resp_addr;
    resp_id_d    = resp_id;
    resp_err_d   = resp_err;
    pop          = 1'b0;
    rd_inc       = 1'b0;
    wb_inc       = 1'b0;
    cand         = slots[rd_ptr];
    cand_valid   = 1'b0;
    due_diff     = 32'd0;
    cand_due     = 1'b0;

    case (state)
      RESP: begin
        if (resp_ready) begin
          pop    = 1'b1;
          rd_inc = 1'b1;
        end
      end
      RETIRE: begin
        pop    = 1'b1;
        wb_inc = ~slots[rd_ptr].err;
      end
      default: ;
    endcase

    count_d = count + CNT_W'(push) - CNT_W'(pop);

    if (pop) begin
      cand       = slots[rd_ptr_nxt];
      cand_valid = (count > CNT_W'(1));
    end else begin
      cand_valid = (count != '0);
    end

    due_diff = cyc_next - cand.due;
    cand_due = cand_valid && !due_diff[31];

    // A stalled response holds everything; otherwise re-evaluate the head
    if (!(state == RESP && !resp_ready)) begin
      resp_valid_d = 1'b0;
      if (cand_due) begin
        if (cand.write) begin
          state_d = RETIRE;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_addr_d  = cand.addr;
          resp_id_d    = cand.id;
          resp_err_d   = cand.err;
        end
      end else if (count_d != '0) begin
        state_d = WAIT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // FSM state and response output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_addr  <= 32'd0;
      resp_id    <= 2'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      resp_valid <= resp_valid_d;
      resp_addr  <= resp_addr_d;
      resp_id    <= resp_id_d;
      resp_err   <= resp_err_d;
    end
  end

  // Queue bookkeeping, free-running cycle counter and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc       <= 32'd0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_ready <= 1'b1;
    end else begin
      cyc       <= cyc_next;
      count     <= count_d;
      req_ready <= (count_d != DEPTH_C);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
    end
  end

  // Delivered-read and retired-writeback counters (wrap modulo 2^32)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 32'd0;
      wb_count <= 32'd0;
    end else begin
      if (rd_inc) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wb_inc) begin
        wb_count <= wb_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed testbench for line_fill_responder (DELAY=8, DEPTH=4, MEM_BYTES=0x10000).
// "Cycle k" is the clock period ending at posedge k; inputs are driven and
// outputs sampled at the negedge inside that period.
module tb_line_fill_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_id;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_addr;
  logic [1:0]  resp_id;
  logic        resp_err;
  logic [31:0] rd_count;
  logic [31:0] wb_count;

`ifdef MEM_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int          checks;
  int          errors;
  int          k;
  logic [31:0] exp_rd;
  logic [31:0] exp_wb;

  line_fill_responder #(
    .DELAY      (8),
    .DEPTH      (4),
    .LINE_BYTES (64),
    .MEM_BYTES  (32'h0001_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_id     (req_id),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .rd_count   (rd_count),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(negedge clk);
    k++;
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] id);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_id    = id;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_id    = 2'd0;
  endtask

  task automatic start();
    idle_req();
    repeat (3) @(negedge clk);
    k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_req();
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_addr !== 32'd0 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%0b addr=%h id=%0d err=%0b expected all zero",
               resp_valid, resp_addr, resp_id, resp_err);
    end
    checks++;
    if (rd_count !== 32'd0 || wb_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: got rd=%0d wb=%0d expected 0 0", rd_count, wb_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b expected 1", req_ready);
    end
  endtask

  task automatic test_single_read();
    logic bad;
    start();
    resp_ready = 1'b1;
    drive_req(1'b0, 32'h0000_1047, 2'd2);
    next();
    idle_req();
    bad = 1'b0;
    while (k < 8) begin
      if (resp_valid !== 1'b0) bad = 1'b1;
      next();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_early: got resp_valid=1 before cycle 8 expected 0");
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_addr !== 32'h0000_1040 || resp_id !== 2'd2 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got valid=%0b addr=%h id=%0d err=%0b expected 1 00001040 2 0",
               resp_valid, resp_addr, resp_id, resp_err);
    end
    next();
    exp_rd = exp_rd + 32'd1;
    checks++;
    if (resp_valid !== 1'b0 || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL single_after: got valid=%0b rd=%0d expected 0 %0d", resp_valid, rd_count, exp_rd);
    end
  endtask

  task automatic test_fill_queue();
    logic bad;
    logic [31:0] exp_addr;
    start();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'h0000_4000 + 32'(i * 64) + 32'(i), 2'(i));
      next();
    end
    idle_req();
    bad = 1'b0;
    while (k < 9) begin
      if (req_ready !== 1'b0) bad = 1'b1;
      next();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL full_ready: got req_ready=1 in cycles 4..8 expected 0");
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_back: got %0b expected 1 at cycle 9", req_ready);
    end
    // cycle 8 already passed; check the ordering via cycles 9..11 and rd_count
    for (int i = 1; i < 4; i++) begin
      exp_addr = 32'h0000_4000 + 32'(i * 64);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(i) || resp_addr !== exp_addr) begin
        errors++;
        $display("FAIL order_%0d: got valid=%0b id=%0d addr=%h expected 1 %0d %h",
                 i, resp_valid, resp_id, resp_addr, i, exp_addr);
      end
      next();
    end
    exp_rd = exp_rd + 32'd4;
    checks++;
    if (resp_valid !== 1'b0 || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL fill_done: got valid=%0b rd=%0d expected 0 %0d", resp_valid, rd_count, exp_rd);
    end
  endtask

  task automatic test_first_of_four();
    start();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 32'h0000_9000 + 32'(i * 64), 2'(3 - i));
      next();
    end
    idle_req();
    while (k < 8) next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_addr !== 32'h0000_9000) begin
      errors++;
      $display("FAIL first_of_four: got valid=%0b id=%0d addr=%h expected 1 3 00009000",
               resp_valid, resp_id, resp_addr);
    end
    repeat (5) next();
    exp_rd = exp_rd + 32'd4;
  endtask

  task automatic test_writeback();
    start();
    resp_ready = 1'b1;
    drive_req(1'b1, 32'h0000_2000, 2'd0);
    next();
    drive_req(1'b0, 32'h0000_3000, 2'd1);
    next();
    idle_req();
    while (k < 8) next();
    checks++;
    if (resp_valid !== 1'b0 || wb_count !== exp_wb) begin
      errors++;
      $display("FAIL wb_c8: got valid=%0b wb=%0d expected 0 %0d", resp_valid, wb_count, exp_wb);
    end
    next();
    exp_wb = exp_wb + 32'd1;
    checks++;
    if (wb_count !== exp_wb) begin
      errors++;
      $display("FAIL wb_count: got %0d expected %0d", wb_count, exp_wb);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL wb_read_resp: got valid=%0b id=%0d addr=%h expected 1 1 00003000",
               resp_valid, resp_id, resp_addr);
    end
    next();
    exp_rd = exp_rd + 32'd1;
    checks++;
    if (resp_valid !== 1'b0 || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL wb_done: got valid=%0b rd=%0d expected 0 %0d", resp_valid, rd_count, exp_rd);
    end
  endtask

  task automatic test_backpressure();
    logic bad;
    start();
    resp_ready = 1'b0;
    drive_req(1'b0, 32'h0000_5000, 2'd0);
    next();
    drive_req(1'b0, 32'h0000_60BF, 2'd3);
    next();
    idle_req();
    while (k < 8) next();
    bad = 1'b0;
    while (k < 13) begin
      if (resp_valid !== 1'b1 || resp_addr !== 32'h0000_5000 || resp_id !== 2'd0) bad = 1'b1;
      next();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: got unstable response in cycles 8..12 expected valid id 0 addr 00005000");
    end
    checks++;
    if (rd_count !== exp_rd) begin
      errors++;
      $display("FAIL stall_count: got %0d expected %0d", rd_count, exp_rd);
    end
    resp_ready = 1'b1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin
      errors++;
      $display("FAIL stall_c13: got valid=%0b id=%0d expected 1 0", resp_valid, resp_id);
    end
    next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_addr !== 32'h0000_6080) begin
      errors++;
      $display("FAIL stall_c14: got valid=%0b id=%0d addr=%h expected 1 3 00006080",
               resp_valid, resp_id, resp_addr);
    end
    next();
    exp_rd = exp_rd + 32'd2;
    checks++;
    if (resp_valid !== 1'b0 || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL stall_done: got valid=%0b rd=%0d expected 0 %0d", resp_valid, rd_count, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    start();
    resp_ready = 1'b1;
    drive_req(1'b0, 32'h0000_7000, 2'd1);
    next();
    drive_req(1'b0, 32'h0000_7010, 2'd2);
    next();
    idle_req();
    while (k < 8) next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_addr !== 32'h0000_7000) begin
      errors++;
      $display("FAIL dup_first: got valid=%0b id=%0d addr=%h expected 1 1 00007000",
               resp_valid, resp_id, resp_addr);
    end
    // push lands on the same edge as the pop
    drive_req(1'b0, 32'h0000_8000, 2'd0);
    next();
    idle_req();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_addr !== 32'h0000_7000 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL dup_second: got valid=%0b id=%0d addr=%h ready=%0b expected 1 2 00007000 1",
               resp_valid, resp_id, resp_addr, req_ready);
    end
    next();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dup_gap: got %0b expected 0", resp_valid);
    end
    while (k < 16) next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_addr !== 32'h0000_8000) begin
      errors++;
      $display("FAIL pushpop_resp: got valid=%0b id=%0d addr=%h expected 1 0 00008000",
               resp_valid, resp_id, resp_addr);
    end
    next();
    exp_rd = exp_rd + 32'd3;
    checks++;
    if (rd_count !== exp_rd) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_mem_err();
    start();
    resp_ready = 1'b1;
    drive_req(1'b0, 32'h0001_0000, 2'd1);
    next();
    drive_req(1'b0, 32'h0000_FFFF, 2'd2);
    next();
    drive_req(1'b1, 32'h0001_0040, 2'd0);
    next();
    idle_req();
    while (k < 8) next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_addr !== 32'h0001_0000 || resp_err !== EXP_ERR) begin
      errors++;
      $display("FAIL err_high: got valid=%0b id=%0d addr=%h err=%0b expected 1 1 00010000 %0b",
               resp_valid, resp_id, resp_addr, resp_err, EXP_ERR);
    end
    next();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_addr !== 32'h0000_FFC0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL err_low: got valid=%0b id=%0d addr=%h err=%0b expected 1 2 0000ffc0 0",
               resp_valid, resp_id, resp_addr, resp_err);
    end
    next();
    next();
    exp_rd = exp_rd + 32'd2;
    if (!EXP_ERR) exp_wb = exp_wb + 32'd1;
    checks++;
    if (wb_count !== exp_wb || rd_count !== exp_rd) begin
      errors++;
      $display("FAIL err_counts: got wb=%0d rd=%0d expected %0d %0d", wb_count, rd_count, exp_wb, exp_rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic bad;
    start();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 32'h0000_A000 + 32'(i * 64), 2'(i));
      next();
    end
    idle_req();
    while (k < 5) next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    bad = 1'b0;
    while (k < 20) begin
      if (resp_valid !== 1'b0) bad = 1'b1;
      next();
    end
    if (resp_valid !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midreset_resp: got resp_valid=1 after reset expected 0");
    end
    exp_rd = 32'd0;
    exp_wb = 32'd0;
    checks++;
    if (rd_count !== exp_rd || wb_count !== exp_wb || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got rd=%0d wb=%0d ready=%0b expected 0 0 1",
               rd_count, wb_count, req_ready);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    k          = 0;
    exp_rd     = 32'd0;
    exp_wb     = 32'd0;
    rst        = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_id     = 2'd0;

    test_reset();
    test_single_read();
    test_first_of_four();
    test_fill_queue();
    test_writeback();
    test_backpressure();
    test_back_to_back();
    test_mem_err();
    test_reset_mid_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
